// File: rtl/dmem_responder.sv
//-----------------------------------------------------------------------------
// dmem_responder
//
// Memory-side end of the pipeline's data-access interface. Accepts one read or
// write request at a time, waits WAIT_CYCLES wait states, commits the access
// to an internal word array and presents a response until it is consumed.
//
// Parameters:
//   DEPTH        number of 32-bit words (power of two, 4..4096)
//   WAIT_CYCLES  wait states between accept and commit (0..15)
//
// Ports:
//   CLK        in   clock, all state updates on the rising edge
//   rst_n      in   asynchronous active-low reset
//   req_valid  in   request present
//   req_ready  out  responder can accept a request (high only in IDLE)
//   req_we     in   1 = write, 0 = read
//   req_addr   in   byte address
//   req_wdata  in   write data
//   rsp_valid  out  response present (high only in RESP)
//   rsp_ready  in   requester consumes the response
//   rsp_rdata  out  read data; 0 for writes and errored accesses
//   rsp_err    out  access rejected (out of range, or misaligned when checked)
//   busy       out  high whenever the FSM is not in IDLE
//
// Build option:
//   DMEM_ALIGN_CHECK_EN  when defined, accesses with req_addr[1:0] != 0 are
//                        rejected; otherwise they act on the containing word.
//-----------------------------------------------------------------------------
module dmem_responder #(
    parameter int DEPTH       = 256,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        CLK,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        busy
);

    localparam int AW = $clog2(DEPTH);

`ifdef DMEM_ALIGN_CHECK_EN
    localparam bit ALIGN_CHK = 1'b1;
`else
    localparam bit ALIGN_CHK = 1'b0;
`endif

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t      r_state;
    logic [3:0]  r_cnt;
    logic        r_req_ready;
    logic        r_rsp_valid;
    logic [31:0] r_rsp_rdata;
    logic        r_rsp_err;
    logic        r_busy;

    // Request captured at the accept edge; later input changes are ignored.
    logic        r_we;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;

    // Word storage: never reset, powers up X.
    logic [31:0] r_mem [DEPTH];

    logic          w_accept;
    logic          w_commit;
    logic [AW-1:0] w_idx;
    logic          w_oor;
    logic          w_misalign;
    logic          w_err;
    logic          w_mem_we;

    assign w_accept   = (r_state == ST_IDLE) && req_valid;
    assign w_commit   = (r_state == ST_WAIT) && (r_cnt == 4'd0);
    assign w_idx      = r_addr[AW+1:2];
    assign w_oor      = |r_addr[31:AW+2];
    // Low address bits only matter when alignment checking is built in.
    assign w_misalign = ALIGN_CHK && (|r_addr[1:0]);
    assign w_err      = w_oor || w_misalign;
    assign w_mem_we   = w_commit && r_we && !w_err;

    // Request latch and array write. In reset the FSM sits in IDLE, so no
    // commit can happen; a write still waiting in WAIT is simply dropped.
    always_ff @(posedge CLK) begin
        if (w_accept) begin
            r_we    <= req_we;
            r_addr  <= req_addr;
            r_wdata <= req_wdata;
        end
        if (w_mem_we) begin
            r_mem[w_idx] <= r_wdata;
        end
    end

    // Control FSM with registered outputs.
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_cnt       <= 4'd0;
            r_req_ready <= 1'b1;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= 32'd0;
            r_rsp_err   <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (req_valid) begin
                        r_cnt       <= 4'(WAIT_CYCLES);
                        r_state     <= ST_WAIT;
                        r_req_ready <= 1'b0;
                        r_busy      <= 1'b1;
                    end
                end
                ST_WAIT: begin
                    if (r_cnt != 4'd0) begin
                        r_cnt <= r_cnt - 4'd1;
                    end else begin
                        // Commit edge: the array write happens on this same
                        // edge in the latch/array block above.
                        r_state     <= ST_RESP;
                        r_rsp_valid <= 1'b1;
                        r_rsp_err   <= w_err;
                        r_rsp_rdata <= (!r_we && !w_err) ? r_mem[w_idx] : 32'd0;
                    end
                end
                ST_RESP: begin
                    // req_valid is ignored here; nothing is queued.
                    if (rsp_ready) begin
                        r_state     <= ST_IDLE;
                        r_rsp_valid <= 1'b0;
                        r_rsp_rdata <= 32'd0;
                        r_rsp_err   <= 1'b0;
                        r_req_ready <= 1'b1;
                        r_busy      <= 1'b0;
                    end
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_cnt       <= 4'd0;
                    r_req_ready <= 1'b1;
                    r_rsp_valid <= 1'b0;
                    r_rsp_rdata <= 32'd0;
                    r_rsp_err   <= 1'b0;
                    r_busy      <= 1'b0;
                end
            endcase
        end
    end

    assign req_ready = r_req_ready;
    assign rsp_valid = r_rsp_valid;
    assign rsp_rdata = r_rsp_rdata;
    assign rsp_err   = r_rsp_err;
    assign busy      = r_busy;

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Multi-cycle, handshaked data-memory responder: the memory-side end of the pipeline's data-access interface. Accepts one read or write request at a time from the CPU's memory-access stage, waits a fixed number of wait-state cycles, commits the access to an internal word array and returns a response. Lets the pipeline be exercised against a memory that is not single-cycle.

## Interface
Parameters:
- DEPTH, 256: number of 32-bit words; power of two, 4..4096.
- WAIT_CYCLES, 2: wait states between accept and commit; 0..15.

Ports:
- CLK  in  1  single clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  responder can accept a request.
- req_we  in  1  1 = write, 0 = read.
- req_addr  in  32  byte address.
- req_wdata  in  32  write data.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  requester consumes the response.
- rsp_rdata  out  32  read data; 0 for writes and errored accesses.
- rsp_err  out  1  access rejected.
- busy  out  1  high in any state other than IDLE.

## Operation
- FSM states: IDLE, WAIT, RESP.
- IDLE: req_ready=1, rsp_valid=0. On req_valid && req_ready, latch we/addr/wdata, load wait counter with WAIT_CYCLES, go to WAIT.
- WAIT: req_ready=0. If counter != 0, decrement it. If counter == 0, commit the access on that edge and go to RESP.
- Commit:
  - Word index = req_addr[log2(DEPTH)+1:2].
  - Out of range (any bit of req_addr above log2(DEPTH)+1 set) → rsp_err=1, no array write, rsp_rdata=0.
  - Valid read → rsp_rdata = array[index].
  - Valid write → array[index] = wdata, rsp_rdata = 0.
- RESP: rsp_valid=1; rsp_rdata and rsp_err are held stable until rsp_ready. On rsp_valid && rsp_ready, go to IDLE.
- Request inputs are sampled only at the accept edge; later changes are ignored.
- The array is not reset and powers up X; all control and output registers are reset.

## Timing
- Reset values: req_ready=1 (state IDLE), rsp_valid=0, rsp_rdata=0, rsp_err=0, busy=0, counter=0.
- Latency: with accept on edge E, rsp_valid rises after edge E+WAIT_CYCLES+1. WAIT_CYCLES=0 gives a response one edge after accept.
- Throughput: at most one request per WAIT_CYCLES+3 cycles; the RESP→IDLE edge adds one bubble before the next accept.
- Backpressure: rsp_ready low holds RESP indefinitely, with outputs stable and req_ready=0.
- Simultaneous events: req_valid in RESP is ignored and never queued. A response is not considered consumed until rsp_ready is sampled high in RESP.
- Reset mid-operation: asynchronously returns to IDLE and drops rsp_valid.
  - A write in WAIT that has not yet committed is discarded.
  - A write that has already committed stays in the array.
- Read after write to the same word returns the new data; the write is committed before the read can be accepted.

## Configuration
- DMEM_ALIGN_CHECK_EN defined: req_addr[1:0] != 0 → rsp_err=1, write suppressed, rsp_rdata=0. Latency is unchanged.
- Not defined: req_addr[1:0] are ignored and misaligned accesses act on the containing word. The out-of-range check is always active regardless of this macro.

## Test plan
- Reset then idle: after rst_n rises → req_ready=1, busy=0, rsp_valid=0, rsp_rdata=0, rsp_err=0.
- Write 0xDEADBEEF to 0x10, then read 0x10, with WAIT_CYCLES=2 and rsp_ready=1 → write response 3 cycles after accept (rdata=0, err=0); read returns 0xDEADBEEF. Repeat with WAIT_CYCLES=0 → 1-cycle latency.
- Read 0x10 with rsp_ready held low for 5 cycles → rsp_valid and rdata held stable for 5 cycles, req_ready=0, a new req_valid is not accepted; IDLE one edge after rsp_ready=1.
- Write 0x12345678 to 0x400 with DEPTH=256 → rsp_err=1; a subsequent read of 0x000 shows that word unchanged.
- Write to 0x13: with DMEM_ALIGN_CHECK_EN → rsp_err=1 and word 4 unchanged; without it → word 4 is written, err=0.
- Assert rst_n low while a write is in WAIT with counter > 0 → outputs return to reset values immediately; reading that address afterwards returns the previous contents.
